// File: rtl/io_bus_pkg.sv
// io_bus_pkg: address map, funct3 codes and byte-lane helpers shared by io_bus_u
package io_bus_pkg;
   localparam logic [7:0] LED_BASE = 8'h80;
   localparam logic [7:0] SW_OFS   = 8'hC0;
   localparam logic [7:0] STAT_OFS = 8'hC4;
   localparam logic [7:0] MASK_OFS = 8'hC8;
   localparam logic [7:0] TCNT_OFS = 8'hCC;
   localparam logic [7:0] TCMP_OFS = 8'hD0;
   localparam int TMR_BIT = 16;
   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } f3_e;
   // stores only have the signed-looking codes; loads also take the unsigned variants
   function automatic logic f3_legal(input logic [2:0] f3, input logic st);
      return st ? f3 inside {F3_B, F3_H, F3_W} : f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction
   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      return f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
   endfunction
   // bit 2 of funct3 set means zero-extend
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      logic [7:0] b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = w[{off[1], 4'b0000} +: 16];
      return f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b} :
             f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : w;
   endfunction
endpackage

// File: rtl/io_bus_u_sw_debounce.sv
// sw_debounce: two-flop synchroniser and per-bit stability counter for the switch pins
module sw_debounce #(
   parameter int SW_W       = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SW_W-1:0] sw,
   output logic [SW_W-1:0] deb,
   output logic [SW_W-1:0] chg
);
   localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic [SW_W-1:0] s1, s2;
   logic [CW-1:0] cnt [SW_W];
   // a bit flips once the synchronised value has disagreed for DEB_CYCLES samples
   always_comb begin
      for (int i = 0; i < SW_W; i++) chg[i] = s2[i] != deb[i] && cnt[i] == CW'(DEB_CYCLES - 1);
   end
   // synchroniser, debounced value and counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1  <= '0;
         s2  <= '0;
         deb <= '0;
         for (int i = 0; i < SW_W; i++) cnt[i] <= '0;
      end else begin
         s1  <= sw;
         s2  <= s1;
         deb <= deb ^ chg;
         for (int i = 0; i < SW_W; i++) cnt[i] <= s2[i] != deb[i] && !chg[i] ? cnt[i] + 1'b1 : '0;
      end
   end
endmodule

// File: rtl/io_bus_u.sv
// io_bus_u: CPU load/store decoder for scratch RAM, LED ports, debounced switches and a compare timer (IO_TIMER_EN)
module io_bus_u
   import io_bus_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_OUT    = 2,
   parameter int SW_W       = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [31:0]        wdata,
   input  logic [2:0]         funct3,
   output logic [31:0]        rdata,
   output logic               rvalid,
   output logic               err,
   input  logic [SW_W-1:0]    sw,
   output logic [NUM_OUT*8-1:0] leds_out,
   output logic               irq
);
   localparam int AW = $clog2(DEPTH);
`ifdef IO_TIMER_EN
   localparam logic [31:0] VMASK = (32'd1 << TMR_BIT) | ((32'd1 << SW_W) - 32'd1);
`else
   localparam logic [31:0] VMASK = (32'd1 << SW_W) - 32'd1;
`endif
   logic [7:0] a;
   logic [1:0] off;
   logic [3:0] li, bm;
   logic [31:0] bm32, wsh, cur, merged, set, clr, status, mask, tcount, tcmp;
   logic [SW_W-1:0] deb, chg;
   logic is_ram, is_led, sel_sw, sel_st, sel_mk, sel_tc, sel_tm, hit, mis, bad, wr, rd, tmatch;
   logic [31:0] mem [DEPTH];

   assign a      = addr[7:0];
   assign off    = a[1:0];
   assign li     = a[5:2];
   assign mis    = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
   assign is_ram = !a[7];
   assign is_led = {a[7:6], 6'b0} == LED_BASE && {1'b0, li} < 5'(NUM_OUT);
   assign sel_sw = {a[7:2], 2'b00} == SW_OFS;
   assign sel_st = {a[7:2], 2'b00} == STAT_OFS;
   assign sel_mk = {a[7:2], 2'b00} == MASK_OFS;
   assign sel_tc = {a[7:2], 2'b00} == TCNT_OFS;
   assign sel_tm = {a[7:2], 2'b00} == TCMP_OFS;
   assign hit    = is_ram | is_led | sel_sw | sel_st | sel_mk | sel_tc | sel_tm;
   assign bad    = req && (!f3_legal(funct3, we) || mis || !hit);
   assign wr     = req && we && !bad;
   assign rd     = req && !we && !bad;
   assign bm     = lane_mask(funct3, off);
   assign bm32   = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
   assign wsh    = wdata << {off, 3'b000};
   assign cur    = is_ram ? mem[a[2 +: AW]] : is_led ? {24'b0, leds_out[{li, 3'b000} +: 8]} :
                   sel_sw ? 32'(deb) : sel_st ? status : sel_mk ? mask :
                   sel_tc ? tcount : sel_tm ? tcmp : '0;
   assign merged = (cur & ~bm32) | (wsh & bm32);
   assign set    = (32'(tmatch) << TMR_BIT) | 32'(chg);
   assign clr    = wr && sel_st ? wsh & bm32 : '0;

   sw_debounce #(.SW_W(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .sw(sw), .deb(deb), .chg(chg)
   );

   // scratch RAM keeps unwritten lanes through the merge with the current word
   always_ff @(posedge clk) begin
      if (wr && is_ram) mem[a[2 +: AW]] <= merged;
   end

`ifdef IO_TIMER_EN
   assign tmatch = tcount == tcmp;
   // free-running counter; a store to TCOUNT overrides the increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcount <= '0;
         tcmp   <= '0;
      end else begin
         tcount <= wr && sel_tc ? merged : tcount + 32'd1;
         if (wr && sel_tm) tcmp <= merged;
      end
   end
`else
   assign tmatch = 1'b0;
   assign tcount = '0;
   assign tcmp   = '0;
`endif

   // response, output ports, status/mask and registered interrupt
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata    <= '0;
         rvalid   <= 1'b0;
         err      <= 1'b0;
         leds_out <= '0;
         status   <= '0;
         mask     <= '0;
         irq      <= 1'b0;
      end else begin
         rvalid <= rd;
         err    <= bad;
         if (req && !we) rdata <= rd ? load_ext(cur, funct3, off) : '0;
         if (wr && is_led) leds_out[{li, 3'b000} +: 8] <= merged[7:0];
         status <= ((status & ~clr) | set) & VMASK;
         if (wr && sel_mk) mask <= merged & VMASK;
         irq <= |(status & mask);
      end
   end
endmodule

// File: tb/tb_io_bus_u.sv
// tb_io_bus_u: directed and randomized checks of io_bus_u against a behavioural model
module tb_io_bus_u;
   localparam int NUM_OUT = 2, SW_W = 8, DEB = 4, DEPTH = 16;
`ifdef IO_TIMER_EN
   localparam bit TMR = 1'b1;
   localparam logic [31:0] VM = 32'h0001_00FF;
`else
   localparam bit TMR = 1'b0;
   localparam logic [31:0] VM = 32'h0000_00FF;
`endif
   logic clk = 0, rst = 1, req = 0, we = 0;
   logic [7:0] addr = 0;
   logic [31:0] wdata = 0;
   logic [2:0] funct3 = 0;
   logic [SW_W-1:0] sw = 0;
   logic [31:0] rdata;
   logic rvalid, err, irq;
   logic [NUM_OUT*8-1:0] leds_out;

   io_bus_u #(.ADDR_W(8), .DEPTH(DEPTH), .NUM_OUT(NUM_OUT), .SW_W(SW_W), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
      .rdata(rdata), .rvalid(rvalid), .err(err), .sw(sw), .leds_out(leds_out), .irq(irq)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model state
   logic [7:0] ram [DEPTH*4];
   bit kb [DEPTH*4];
   logic [7:0] led [NUM_OUT];
   logic [31:0] status, mask, tcnt, tcmp, e_rdata;
   logic [SW_W-1:0] deb_m, d1, d2;
   int run [SW_W];
   logic e_rvalid, e_err, e_irq;
   bit e_known;

   function automatic bit is_led(input int a);
      return a >= 128 && a < 128 + 4 * NUM_OUT;
   endfunction
   function automatic bit mapped(input int a);
      int aw = a & ~3;
      return a < 128 || is_led(a) || aw inside {'hC0, 'hC4, 'hC8, 'hCC, 'hD0};
   endfunction
   function automatic logic [31:0] reg_word(input int a);
      int aw = a & ~3, b = ((a / 4) % DEPTH) * 4;
      if (a < 128) return {ram[b+3], ram[b+2], ram[b+1], ram[b]};
      if (is_led(a)) return {24'h0, led[(aw - 128) / 4]};
      case (aw)
         'hC0: return 32'(deb_m);
         'hC4: return status;
         'hC8: return mask;
         'hCC: return tcnt;
         'hD0: return tcmp;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      status = 0; mask = 0; tcnt = 0; tcmp = 0; deb_m = 0; d1 = 0; d2 = 0;
      foreach (run[i]) run[i] = 0;
      foreach (led[i]) led[i] = 0;
      foreach (kb[i]) kb[i] = 0;
      e_rvalid = 0; e_err = 0; e_irq = 0; e_rdata = 0; e_known = 0;
   endtask

   task automatic model_step();
      int a, sz, off, base;
      bit legal, ok;
      logic [31:0] rw, nw, set, clr, val, tnext;
      a = int'(addr);
      off = a % 4;
      base = ((a / 4) % DEPTH) * 4;
      sz = funct3[1:0] == 0 ? 1 : funct3[1:0] == 1 ? 2 : funct3[1:0] == 2 ? 4 : 0;
      legal = we ? funct3 <= 2 : funct3 inside {0, 1, 2, 4, 5};
      ok = legal && sz != 0 && off % sz == 0 && mapped(a);
      rw = reg_word(a);
      set = 0;
      for (int i = 0; i < SW_W; i++) begin
         run[i] = d2[i] != deb_m[i] ? run[i] + 1 : 0;
         if (run[i] == DEB) begin
            run[i] = 0;
            set[i] = 1'b1;
         end
      end
      if (TMR && tcnt == tcmp) set[16] = 1'b1;
      e_irq = |(status & mask);
      e_rvalid = req && !we && ok;
      e_err = req && !ok;
      if (req && !we) begin
         val = rw >> (8 * off);
         if (sz == 1) val = funct3[2] ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
         if (sz == 2) val = funct3[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
         e_rdata = ok ? val : 0;
         e_known = 1;
         if (ok && a < 128) for (int j = 0; j < sz; j++) if (!kb[base+off+j]) e_known = 0;
      end
      clr = 0;
      tnext = tcnt + 1;
      if (req && we && ok) begin
         nw = rw;
         for (int j = 0; j < sz; j++) nw[8*(off+j) +: 8] = wdata[8*j +: 8];
         if (a < 128) begin
            for (int j = 0; j < sz; j++) begin
               ram[base+off+j] = wdata[8*j +: 8];
               kb[base+off+j] = 1;
            end
         end else if (is_led(a)) led[(a - 128) / 4] = nw[7:0];
         else case (a & ~3)
            'hC4: for (int j = 0; j < sz; j++) clr[8*(off+j) +: 8] = wdata[8*j +: 8];
            'hC8: mask = nw & VM;
            'hCC: tnext = nw;
            'hD0: if (TMR) tcmp = nw;
            default: ;
         endcase
      end
      if (TMR) tcnt = tnext;
      status = ((status & ~clr) | set) & VM;
      deb_m = deb_m ^ set[SW_W-1:0];
      d2 = d1;
      d1 = sw;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   // compare every cycle away from the active edge
   always @(negedge clk) begin : cmp
      logic [NUM_OUT*8-1:0] el;
      for (int i = 0; i < NUM_OUT; i++) el[8*i +: 8] = led[i];
      chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("err", 32'(err), 32'(e_err));
      chk("irq", 32'(irq), 32'(e_irq));
      chk("leds", 32'(leds_out), 32'(el));
      if (e_rvalid && e_known) chk("rdata", rdata, e_rdata);
   end

   task automatic acc(input bit w, input logic [7:0] a, input logic [2:0] f, input logic [31:0] d);
      @(negedge clk);
      req = 1; we = w; addr = a; funct3 = f; wdata = d;
      @(negedge clk);
      req = 0; we = 0;
   endtask
   task automatic ldchk(input string n, input logic [7:0] a, input logic [2:0] f, input logic [31:0] exp);
      acc(0, a, f, 0);
      chk({n, "_rvalid"}, 32'(rvalid), 1);
      chk(n, rdata, exp);
   endtask
   task automatic errchk(input string n, input bit w, input logic [7:0] a, input logic [2:0] f);
      acc(w, a, f, 32'hDEADBEEF);
      chk({n, "_err"}, 32'(err), 1);
      chk({n, "_rvalid"}, 32'(rvalid), 0);
   endtask

   initial begin
      #1 rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      chk("rst_leds", 32'(leds_out), 0);
      chk("rst_irq", 32'(irq), 0);
      // RAM lanes and sign extension
      acc(1, 8'h10, 3'd2, 32'h12345678);
      acc(1, 8'h11, 3'd0, 32'h000000AA);
      ldchk("lw10", 8'h10, 3'd2, 32'h1234AA78);
      ldchk("lb11", 8'h11, 3'd0, 32'hFFFFFFAA);
      ldchk("lbu11", 8'h11, 3'd4, 32'h000000AA);
      ldchk("lh12", 8'h12, 3'd1, 32'h00001234);
      // misaligned and illegal
      errchk("lh03", 0, 8'h03, 3'd1);
      errchk("sw82", 1, 8'h82, 3'd2);
      errchk("sw_f3_4", 1, 8'h10, 3'd4);
      ldchk("lw10_keep", 8'h10, 3'd2, 32'h1234AA78);
      chk("leds_keep", 32'(leds_out), 0);
      // LED ports and unmapped
      acc(1, 8'h84, 3'd0, 32'h0000005A);
      chk("leds_5a", 32'(leds_out), 32'h5A00);
      ldchk("led1", 8'h84, 3'd2, 32'h0000005A);
      errchk("un88", 0, 8'h88, 3'd2);
      acc(1, 8'hC0, 3'd2, 32'hFFFF);
      chk("ro_noerr", 32'(err), 0);
      // back-to-back store then load
      @(negedge clk);
      req = 1; we = 1; addr = 8'h30; funct3 = 3'd2; wdata = 32'hA5A5_0F0F;
      @(negedge clk);
      we = 0;
      @(negedge clk);
      req = 0;
      chk("b2b", rdata, 32'hA5A5_0F0F);
      // switch debounce with glitch
      acc(1, 8'hC8, 3'd2, 32'h1);
      sw = 8'h01;
      repeat (3) @(negedge clk);
      sw = 8'h00;
      repeat (2) @(negedge clk);
      sw = 8'h01;
      repeat (3) @(negedge clk);
      chk("glitch_irq", 32'(irq), 0);
      repeat (10) @(negedge clk);
      chk("sw_irq", 32'(irq), 1);
      ldchk("stat_sw", 8'hC4, 3'd2, 32'h1);
      ldchk("sw_val", 8'hC0, 3'd2, 32'h1);
      acc(1, 8'hC4, 3'd2, 32'h1);
      @(negedge clk);
      chk("w1c_irq", 32'(irq), 0);
`ifdef IO_TIMER_EN
      acc(1, 8'hC8, 3'd2, 32'h10000);
      acc(1, 8'hD0, 3'd2, 32'd10);
      acc(1, 8'hCC, 3'd2, 32'd0);
      acc(1, 8'hC4, 3'd2, 32'hFFFFFFFF);
      repeat (12) @(negedge clk);
      chk("tmr_irq", 32'(irq), 1);
      ldchk("tmr_stat", 8'hC4, 3'd2, 32'h10000);
      acc(1, 8'hCC, 3'd2, 32'hFFFFFFFF);
      ldchk("tmr_wrap", 8'hCC, 3'd2, 32'h0);
      acc(1, 8'hC8, 3'd2, 32'h0);
`else
      acc(1, 8'hD0, 3'd2, 32'd5);
      chk("tcmp_noerr", 32'(err), 0);
      ldchk("tcmp0", 8'hD0, 3'd2, 32'h0);
      ldchk("tcnt0", 8'hCC, 3'd2, 32'h0);
`endif
      // reset during a load
      @(negedge clk);
      req = 1; we = 0; addr = 8'h10; funct3 = 3'd2;
      #2 rst = 0;
      @(negedge clk);
      req = 0; rst = 1;
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_leds2", 32'(leds_out), 0);
      acc(1, 8'h20, 3'd2, 32'hCAFEF00D);
      ldchk("post_rst", 8'h20, 3'd2, 32'hCAFEF00D);
      // randomized traffic, every cycle compared against the model
      repeat (3000) begin
         @(negedge clk);
         req = $urandom % 4 != 0;
         we = $urandom % 2 == 1;
         case ($urandom % 4)
            0: addr = 8'($urandom % 32);
            1: addr = 8'(8'h80 + $urandom % 16);
            2: addr = 8'(8'hC0 + $urandom % 20);
            default: addr = 8'($urandom % 256);
         endcase
         funct3 = 3'($urandom % 8);
         wdata = $urandom;
         if ($urandom % 25 == 0) sw = SW_W'($urandom);
      end
      @(negedge clk);
      req = 0;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/io_bus_u.md
Name: io_bus_u

Overview:
Parametrised successor to the single-port I/O device unit. It decodes one CPU load/store per request into:
- a byte-lane scratch RAM,
- NUM_OUT registered 8-bit output ports,
- a synchronised and debounced switch input with edge status,
- an optional compare timer.

It sits between the datapath (ALU address, rs2 data, funct3, mem_write) and the board pins. Read data is registered with one-cycle latency, and the block drives a level interrupt to the core.

Parameters:
ADDR_W, 8, request address width (min 8)
DEPTH, 16, scratch RAM depth in 32-bit words (power of 2, ≤32)
NUM_OUT, 2, number of 8-bit output ports (1..16)
SW_W, 8, switch input width (1..16)
DEB_CYCLES, 4, consecutive stable samples before a switch change is accepted (≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req  in  1  access strobe, one access per asserted cycle
we  in  1  1 = store, 0 = load (qualified by req)
addr  in  ADDR_W  byte address
wdata  in  32  store data (rs2)
funct3  in  3  RV32 width/sign code
rdata  out  32  load result, valid when rvalid
rvalid  out  1  one-cycle pulse, the cycle after a load request
err  out  1  one-cycle pulse, the cycle after a misaligned or unmapped access
sw  in  SW_W  asynchronous switch pins
leds_out  out  NUM_OUT*8  output port registers; port i in bits [8i+7:8i]
irq  out  1  level interrupt

Behaviour:
- Reset (rst low, async):
  - rdata, rvalid, err, leds_out, irq, status, mask, timer and debounce state all 0.
  - RAM contents undefined.
- Address map (addr[7] selects region):
  - 0x00–0x7F: RAM, word index addr[6:2] mod DEPTH.
  - 0x80+4i: LED port i (i < NUM_OUT).
  - 0xC0: SW (RO). Debounced value, zero-extended.
  - 0xC4: STATUS (W1C). Bits [SW_W-1:0] = switch edge; bit 16 = timer match.
  - 0xC8: MASK (RW). Same bit positions as STATUS.
  - 0xCC: TCOUNT (RW).
  - 0xD0: TCMP (RW).
  - Anything else is unmapped: err, no side effect, rdata 0.
- Width and alignment (funct3):
  - 000 = LB, 100 = LBU, 001 = LH, 101 = LHU, 010 = LW; stores use 000/001/010.
  - Byte lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or an illegal funct3 → err pulse, no write, no rvalid.
- RAM stores write only the addressed byte lanes; other lanes are preserved.
- IO register stores:
  - Use the lane-merged value. LED ports keep only bits [7:0] of the merged word.
  - RO writes are ignored with no err.
- Load latency: request in cycle N → rdata/rvalid in cycle N+1. rdata holds its value until the next load.
- Back-to-back requests are accepted every cycle. A load of an address stored in the previous cycle returns the new data.
- Switch input path:
  - 2-flop synchroniser per bit.
  - A per-bit counter increments while the sync value ≠ the debounced value and resets to 0 on agreement.
  - When the counter reaches DEB_CYCLES-1, the debounced bit updates and STATUS bit sets.
- STATUS W1C: a set event in the same cycle as a clear wins (the bit stays 1).
- irq = |(STATUS & MASK), registered (one cycle after STATUS changes).
- Timer:
  - TCOUNT increments every cycle and wraps at 2^32-1 → 0.
  - When TCOUNT == TCMP, STATUS[16] sets.
  - A write to TCOUNT takes priority over the increment that cycle.
- Reset mid-access: the in-flight rvalid/err is dropped.

Optional Feature:
IO_TIMER_EN.
- Defined: TCOUNT/TCMP and STATUS[16] are present as above.
- Undefined: the timer logic is not generated. 0xCC/0xD0 read 0, accept writes silently (no err), and STATUS[16]/MASK[16] read 0.

Decomposition:
- Package io_bus_pkg holds:
  - address offset localparams (LED_BASE, SW_OFS, STAT_OFS, MASK_OFS, TCNT_OFS, TCMP_OFS);
  - a funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the STATUS timer bit index 16;
  - load-extend and store-lane-mask functions.
- One sub-module, sw_debounce: synchroniser plus counter per bit. Parameters SW_W and DEB_CYCLES; outputs the debounced vector and a per-bit change pulse.

Test Plan:
1. SW 0x12345678 to RAM 0x10; SB 0xAA to 0x11; LW 0x10 → 0x1234AA78. LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA. Each rvalid arrives one cycle after req.
2. LH at 0x03, then SW at 0x82 → err pulse each time. RAM unchanged; leds_out unchanged.
3. SB 0x5A to 0x84 with NUM_OUT=2 → leds_out = 0x5A00. Load 0x84 → 0x0000005A. Access to 0x88 → err.
4. sw goes 0x00 → 0x01 with a 2-cycle glitch back to 0x00, DEB_CYCLES=4 → glitch ignored. A stable 0x01 is accepted 2+4 cycles after the last edge, STATUS[0]=1. With MASK=0x1, irq rises one cycle later; W1C 0x1 to 0xC4 drops irq.
5. (IO_TIMER_EN) TCMP=10, TCOUNT=0, MASK=0x10000 → STATUS[16] sets when the count reaches 10 and irq follows. TCOUNT=0xFFFFFFFF wraps to 0.
6. Assert rst low for one cycle mid-load → rvalid stays 0 and leds_out=0; the next access works normally.
